// File: rtl/rsa_pkg.sv
// Shared types and constant helpers for the RSA modular-exponentiation blocks.
package rsa_pkg;

  // Sequencer states for mont_exp_ctrl.
  typedef enum logic [2:0] {
    IDLE,
    LOAD_B,
    LOAD_ONE,
    SQR,
    MUL,
    FINAL
  } mexp_state_t;

  // Widest operand the constant helpers below can build.
  localparam int MAX_LEN = 8192;

  // Integer 1 at MAX_LEN width; callers keep the low LEN bits.
  function automatic logic [MAX_LEN-1:0] lsb_one();
    return {{(MAX_LEN-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/mont_mul.sv
// Single-cycle Montgomery product p = a * b * R^-1 mod n, with R = 2^LEN.
// Inputs a and b must be below n. The result is fully reduced into [0, n).
module mont_mul #(
  parameter int LEN = 2048
) (
  input  logic [LEN-1:0] a_i,
  input  logic [LEN-1:0] b_i,
  input  logic [LEN-1:0] n_i,
  input  logic [LEN-1:0] n_prime_i,
  output logic [LEN-1:0] p_o
);

  localparam int W2 = 2 * LEN;

  logic [W2-1:0] t;
  logic [LEN-1:0] m;
  logic [W2:0]   s;
  logic [LEN:0]  u;
  logic [LEN:0]  d;
  logic          unused_lo;

  // Full product of the operands.
  assign t = W2'(a_i) * W2'(b_i);
  // Reduction factor chosen so t + m*n is a multiple of R; the truncation to LEN bits is the mod R.
  assign m = t[LEN-1:0] * n_prime_i;
  // t + m*n is below 2*n*R, so one extra bit holds it.
  assign s = (W2+1)'(t) + (W2+1)'(m) * (W2+1)'(n_i);
  // Exact division by R; the quotient is below 2n.
  assign u = s[W2:LEN];
  assign d = u - (LEN+1)'(n_i);
  assign p_o = (u >= (LEN+1)'(n_i)) ? d[LEN-1:0] : u[LEN-1:0];

  // The low half of s is zero by construction and the borrow bit of d is not needed.
  assign unused_lo = ^{s[LEN-1:0], d[LEN]};

endmodule

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for res = msg^exp mod n,
// issuing one Montgomery product per clock on a single shared mont_mul.
module mont_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int LEN     = 2048,
  parameter int EXP_LEN = 2048
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LEN-1:0]     msg,
  input  logic [EXP_LEN-1:0] exp,
  input  logic [LEN-1:0]     n,
  input  logic [LEN-1:0]     n_prime,
  input  logic [LEN-1:0]     r2,
  output logic               busy,
  output logic               done,
  output logic [LEN-1:0]     res
);

  localparam int IDX_W = (EXP_LEN > 1) ? $clog2(EXP_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(EXP_LEN - 1);
  localparam logic [MAX_LEN-1:0] ONE_WIDE = lsb_one();
  localparam logic [LEN-1:0] ONE = ONE_WIDE[LEN-1:0];

  mexp_state_t state_q, state_d;

  logic [LEN-1:0]     msg_q, msg_d;
  logic [EXP_LEN-1:0] exp_q, exp_d;
  logic [LEN-1:0]     n_q, n_d;
  logic [LEN-1:0]     np_q, np_d;
  logic [LEN-1:0]     r2_q, r2_d;
  logic [LEN-1:0]     acc_q, acc_d;
  logic [LEN-1:0]     bm_q, bm_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LEN-1:0]     res_q, res_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [LEN-1:0]     op_a, op_b, mm_p;

  // Select multiplier operands from registered state for the current step.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state_q)
      LOAD_B:   begin op_a = msg_q; op_b = r2_q;  end
      LOAD_ONE: begin op_a = ONE;   op_b = r2_q;  end
      SQR:      begin op_a = acc_q; op_b = acc_q; end
      MUL:      begin op_a = acc_q; op_b = bm_q;  end
      FINAL:    begin op_a = acc_q; op_b = ONE;   end
      default:  begin op_a = '0;    op_b = '0;    end
    endcase
  end

  mont_mul #(.LEN(LEN)) u_mont_mul (
    .a_i       (op_a),
    .b_i       (op_b),
    .n_i       (n_q),
    .n_prime_i (np_q),
    .p_o       (mm_p)
  );

  // Next-state logic: one multiplier result is written back per state.
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    exp_d   = exp_q;
    n_d     = n_q;
    np_d    = np_q;
    r2_d    = r2_q;
    acc_d   = acc_q;
    bm_d    = bm_q;
    idx_d   = idx_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          msg_d   = msg;
          exp_d   = exp;
          n_d     = n;
          np_d    = n_prime;
          r2_d    = r2;
          busy_d  = 1'b1;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        bm_d    = mm_p;
        state_d = LOAD_ONE;
      end
      LOAD_ONE: begin
        // mont(1, R^2) is R mod n, the Montgomery form of 1.
        acc_d   = mm_p;
        idx_d   = IDX_TOP;
        state_d = SQR;
      end
      SQR: begin
        acc_d = mm_p;
        if (exp_q[idx_q]) begin
          state_d = MUL;
        end else if (idx_q == '0) begin
          state_d = FINAL;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      MUL: begin
        acc_d = mm_p;
        if (idx_q == '0) begin
          state_d = FINAL;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          state_d = SQR;
        end
      end
      FINAL: begin
        // Multiplying by plain 1 leaves the Montgomery domain.
        res_d   = mm_p;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      msg_q   <= '0;
      exp_q   <= '0;
      n_q     <= '0;
      np_q    <= '0;
      r2_q    <= '0;
      acc_q   <= '0;
      bm_q    <= '0;
      idx_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      exp_q   <= exp_d;
      n_q     <= n_d;
      np_q    <= np_d;
      r2_q    <= r2_d;
      acc_q   <= acc_d;
      bm_q    <= bm_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign res  = res_q;

endmodule
